// File: rtl/t05_cb_mem_arbiter.sv
// Shared-SRAM sequencer for codebook synthesis: 3-beat h-tree element reads, 4-beat codebook writes.
// Optional one-entry element cache enabled by defining CB_ELEM_CACHE_EN.
module t05_cb_mem_arbiter #(
    parameter logic [31:0] HTREE_BASE = 32'h0000_0000,
    parameter logic [31:0] CB_BASE    = 32'h0000_1000
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         rd_req,
    input  logic [6:0]   rd_index,
    output logic [70:0]  h_element,
    output logic         h_valid,
    input  logic         wr_req,
    input  logic [7:0]   wr_index,
    input  logic [127:0] wr_path,
    output logic         write_finish,
    output logic         busy,
    output logic         overrun,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [31:0]  mem_wdata,
    input  logic [31:0]  mem_rdata,
    input  logic         mem_ack
);

    typedef enum logic [2:0] {S_IDLE, S_RD_BEAT, S_WR_BEAT, S_RD_DONE, S_WR_DONE} state_t;

    state_t         r_state, w_next;
    logic [1:0]     r_beat;
    logic           r_rd_pend, r_wr_pend;
    logic [6:0]     r_rd_idx;
    logic [7:0]     r_wr_idx;
    logic [127:0]   r_wr_path;
    logic [63:0]    r_stage;
    logic [70:0]    r_h_elem;
    logic           r_mem_req, r_overrun;
    logic           w_ack, w_in_beat, w_rd_load, w_wr_load;
    logic           w_rd_hit, w_hit_vld;
    logic [70:0]    w_c_elem;

    // An ack with no request outstanding is ignored.
    assign w_ack     = r_mem_req & mem_ack;
    assign w_in_beat = (r_state == S_RD_BEAT) || (r_state == S_WR_BEAT);
    assign w_rd_load = rd_req & ~w_rd_hit;
    assign w_wr_load = wr_req;

`ifdef CB_ELEM_CACHE_EN
    logic        r_c_valid, r_hit;
    logic [6:0]  r_c_idx;
    logic [70:0] r_c_elem;

    assign w_rd_hit  = rd_req & r_c_valid & (r_c_idx == rd_index);
    assign w_hit_vld = r_hit;
    assign w_c_elem  = r_c_elem;

    // Any completed write may alias a fetched element, so it drops the cache.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_c_valid <= 1'b0;
            r_hit     <= 1'b0;
            r_c_idx   <= '0;
            r_c_elem  <= '0;
        end else begin
            r_hit <= w_rd_hit;
            if (r_state == S_WR_DONE) begin
                r_c_valid <= 1'b0;
            end else if (r_state == S_RD_DONE) begin
                r_c_valid <= 1'b1;
                r_c_idx   <= r_rd_idx;
                r_c_elem  <= r_h_elem;
            end
        end
    end
`else
    assign w_rd_hit  = 1'b0;
    assign w_hit_vld = 1'b0;
    assign w_c_elem  = '0;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_wr_pend)      w_next = S_WR_BEAT;
                else if (r_rd_pend) w_next = S_RD_BEAT;
            end
            S_RD_BEAT: if (w_ack && r_beat == 2'd2) w_next = S_RD_DONE;
            S_WR_BEAT: if (w_ack && r_beat == 2'd3) w_next = S_WR_DONE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Request slots; a DONE state frees its slot but a same-cycle pulse refills it.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rd_pend <= 1'b0;
            r_rd_idx  <= '0;
            r_wr_pend <= 1'b0;
            r_wr_idx  <= '0;
            r_wr_path <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (r_state == S_RD_DONE || !r_rd_pend) begin
                r_rd_pend <= w_rd_load;
                if (w_rd_load) r_rd_idx <= rd_index;
            end else if (w_rd_load) begin
                r_overrun <= 1'b1;
            end
            if (r_state == S_WR_DONE || !r_wr_pend) begin
                r_wr_pend <= w_wr_load;
                if (w_wr_load) begin
                    r_wr_idx  <= wr_index;
                    r_wr_path <= wr_path;
                end
            end else if (w_wr_load) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Beat sequencing: request drops on ack and re-asserts after one idle cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_beat    <= '0;
            r_mem_req <= 1'b0;
            r_stage   <= '0;
            r_h_elem  <= '0;
        end else begin
            if (!w_in_beat)  r_beat <= '0;
            else if (w_ack) r_beat <= r_beat + 2'd1;

            if (w_ack)                       r_mem_req <= 1'b0;
            else if (w_in_beat && !r_mem_req) r_mem_req <= 1'b1;

            if (w_ack && r_state == S_RD_BEAT) begin
                if (r_beat == 2'd0) r_stage[31:0]  <= mem_rdata;
                if (r_beat == 2'd1) r_stage[63:32] <= mem_rdata;
            end
            if (w_ack && r_state == S_RD_BEAT && r_beat == 2'd2)
                r_h_elem <= {mem_rdata[6:0], r_stage};
            else if (w_rd_hit)
                r_h_elem <= w_c_elem;
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (r_state == S_RD_BEAT) begin
            mem_addr = HTREE_BASE + {21'd0, r_rd_idx, 4'd0} + {28'd0, r_beat, 2'd0};
        end else if (r_state == S_WR_BEAT) begin
            mem_addr  = CB_BASE + {20'd0, r_wr_idx, 4'd0} + {28'd0, r_beat, 2'd0};
            mem_wdata = r_wr_path[{r_beat, 5'd0} +: 32];
        end
    end

    assign mem_req      = r_mem_req;
    assign mem_we       = (r_state == S_WR_BEAT);
    assign h_element    = r_h_elem;
    assign h_valid      = (r_state == S_RD_DONE) | w_hit_vld;
    assign write_finish = (r_state == S_WR_DONE);
    assign busy         = r_rd_pend | r_wr_pend | (r_state != S_IDLE);
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_t05_cb_mem_arbiter.sv
// Directed + randomized bench for t05_cb_mem_arbiter with a transaction-level memory/arbiter model.
module tb_t05_cb_mem_arbiter;

    logic         clk = 1'b0;
    logic         nrst;
    logic         rd_req, wr_req;
    logic [6:0]   rd_index;
    logic [7:0]   wr_index;
    logic [127:0] wr_path;
    logic [70:0]  h_element;
    logic         h_valid, write_finish, busy, overrun;
    logic         mem_req, mem_we, mem_ack;
    logic [31:0]  mem_addr, mem_wdata, mem_rdata;

    t05_cb_mem_arbiter dut (
        .clk(clk), .nrst(nrst), .rd_req(rd_req), .rd_index(rd_index),
        .h_element(h_element), .h_valid(h_valid), .wr_req(wr_req),
        .wr_index(wr_index), .wr_path(wr_path), .write_finish(write_finish),
        .busy(busy), .overrun(overrun), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic we; logic [31:0] a; logic [31:0] d;} beat_t;

    beat_t log_q[$];
    beat_t exp_q[$];
    int    n_hv = 0, n_wf = 0;
    int    n_chk = 0, n_err = 0;
    bit    ack_rand = 1'b0;

    function automatic logic [31:0] rword(input logic [31:0] a);
        if (a == 32'h50) return 32'hA;
        if (a == 32'h54) return 32'hB;
        if (a == 32'h58) return 32'h7F;
        return (a * 32'h0100_0193) ^ 32'h5BD1_E995;
    endfunction

    function automatic logic [70:0] elem(input logic [6:0] idx);
        logic [31:0] a, w0, w1, w2;
        a  = {21'd0, idx, 4'd0};
        w0 = rword(a);
        w1 = rword(a + 32'd4);
        w2 = rword(a + 32'd8);
        return {w2[6:0], w1, w0};
    endfunction

    assign mem_rdata = rword(mem_addr);

    // Memory answers during the first request cycle, or after a random delay.
    always @(negedge clk) mem_ack = mem_req && (!ack_rand || $urandom_range(0, 1) == 1);

    always @(posedge clk) begin
        if (nrst) begin
            if (mem_req && mem_ack)
                log_q.push_back('{we: mem_we, a: mem_addr, d: (mem_we ? mem_wdata : mem_rdata)});
            if (h_valid)      n_hv++;
            if (write_finish) n_wf++;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_rd(input logic [6:0] idx);
        for (int b = 0; b < 3; b++) begin
            logic [31:0] a;
            a = {21'd0, idx, 4'd0} + 32'(4 * b);
            exp_q.push_back('{we: 1'b0, a: a, d: rword(a)});
        end
    endtask

    task automatic exp_wr(input logic [7:0] idx, input logic [127:0] p);
        for (int b = 0; b < 4; b++)
            exp_q.push_back('{we: 1'b1, a: 32'h1000 + {20'd0, idx, 4'd0} + 32'(4 * b), d: p[32*b +: 32]});
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_nbeats"}, 128'(log_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < log_q.size()) chk({tag, "_beat"}, 128'(log_q[i]), 128'(exp_q[i]));
        log_q.delete();
        exp_q.delete();
    endtask

    // Call at a negedge; the following clock edge samples the pulses (cycle 0).
    task automatic req(input bit r, input logic [6:0] ri, input bit w, input logic [7:0] wi,
                       input logic [127:0] wp);
        rd_req = r; rd_index = ri; wr_req = w; wr_index = wi; wr_path = wp;
    endtask

    task automatic run(input int maxc, output int t_hv, output int t_wf);
        t_hv = -1;
        t_wf = -1;
        for (int k = 1; k <= maxc; k++) begin
            @(negedge clk);
            rd_req = 1'b0;
            wr_req = 1'b0;
            if (h_valid && t_hv < 0)      t_hv = k;
            if (write_finish && t_wf < 0) t_wf = k;
            if (k >= 2 && !busy) break;
        end
        chk("idle_bound", 128'(busy), 128'(0));
    endtask

    initial begin
        int t_hv, t_wf, hv0, wf0, nwr;
        bit m_cv;
        logic [6:0] m_ci;
        logic [127:0] p;

        nrst = 1'b0;
        req(0, '0, 0, '0, '0);
        repeat (3) @(negedge clk);
        chk("reset_state", {h_element, h_valid, write_finish, busy, overrun, mem_req, mem_we,
                            mem_addr, mem_wdata}, '0);
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        // Basic read of element 5.
        exp_rd(7'd5);
        req(1, 7'd5, 0, '0, '0);
        run(50, t_hv, t_wf);
        chk("rd_hvalid_cycle", 128'(t_hv), 128'(8));
        chk("rd_element", 128'(h_element), {57'd0, 7'h7F, 32'hB, 32'hA});
        check_log("rd5");

        // Basic write of entry 0x41.
        p = 128'h1_0000_0002_0000_0003_0000_0004;
        exp_wr(8'h41, p);
        req(0, '0, 1, 8'h41, p);
        run(50, t_hv, t_wf);
        chk("wr_finish_cycle", 128'(t_wf), 128'(10));
        chk("wr_first_addr", 128'(exp_q[0].a), 128'(32'h1410));
        check_log("wr41");

        // Simultaneous requests: write first.
        p = {$urandom, $urandom, $urandom, $urandom};
        exp_wr(8'h07, p);
        exp_rd(7'd3);
        hv0 = n_hv;
        wf0 = n_wf;
        req(1, 7'd3, 1, 8'h07, p);
        run(80, t_hv, t_wf);
        chk("both_wf_before_hv", 128'(t_wf > 0 && t_hv > t_wf), 128'(1));
        chk("both_counts", {64'(n_hv - hv0), 64'(n_wf - wf0)}, {64'd1, 64'd1});
        chk("both_element", 128'(h_element), 128'(elem(7'd3)));
        check_log("both");

        // Second read while the first is still pending.
        exp_rd(7'd5);
        hv0 = n_hv;
        req(1, 7'd5, 0, '0, '0);
        @(negedge clk);
        rd_index = 7'd9;
        run(50, t_hv, t_wf);
        chk("overrun_set", 128'(overrun), 128'(1));
        chk("overrun_hv_count", 128'(n_hv - hv0), 128'(1));
        chk("overrun_element", 128'(h_element), 128'(elem(7'd5)));
        check_log("ovr");

`ifdef CB_ELEM_CACHE_EN
        // Element 5 is now cached: a repeat read is served without memory traffic.
        req(1, 7'd5, 0, '0, '0);
        run(20, t_hv, t_wf);
        chk("hit_hvalid_cycle", 128'(t_hv), 128'(1));
        chk("hit_element", 128'(h_element), 128'(elem(7'd5)));
        check_log("hit");
        p = {$urandom, $urandom, $urandom, $urandom};
        exp_wr(8'h10, p);
        req(0, '0, 1, 8'h10, p);
        run(50, t_hv, t_wf);
        check_log("inval_wr");
        exp_rd(7'd5);
        req(1, 7'd5, 0, '0, '0);
        run(50, t_hv, t_wf);
        chk("miss_hvalid_cycle", 128'(t_hv), 128'(8));
        check_log("miss");
`endif

        // Reset during the third write beat abandons the write.
        wf0 = n_wf;
        req(0, '0, 1, 8'h22, {4{32'hDEAD_BEEF}});
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            wr_req = 1'b0;
            nwr = 0;
            foreach (log_q[i]) if (log_q[i].we) nwr++;
            if (nwr == 2 && mem_req) break;
        end
        chk("rst_reached_beat2", 128'(mem_req), 128'(1));
        nrst = 1'b0;
        #1;
        chk("rst_mem_req_drop", {mem_req, busy, mem_we, write_finish, overrun}, '0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_no_finish", 128'(n_wf - wf0), 128'(0));
        log_q.delete();
        p = {$urandom, $urandom, $urandom, $urandom};
        exp_wr(8'hFF, p);
        req(0, '0, 1, 8'hFF, p);
        run(50, t_hv, t_wf);
        chk("post_rst_finish", 128'(t_wf), 128'(10));
        check_log("post_rst");

        // Randomized single/dual requests with random ack latency.
        m_cv = 1'b0;
        m_ci = '0;
        for (int it = 0; it < 14; it++) begin
            int kind;
            bit hit;
            logic [6:0] ri;
            logic [7:0] wi;
            kind     = $urandom_range(0, 2);
            ri       = 7'($urandom_range(0, 7));
            wi       = 8'($urandom);
            p        = {$urandom, $urandom, $urandom, $urandom};
            ack_rand = 1'($urandom_range(0, 1));
            hit = 1'b0;
`ifdef CB_ELEM_CACHE_EN
            hit = m_cv && m_ci == ri && kind != 1;
`endif
            if (kind != 0)           exp_wr(wi, p);
            if (kind != 1 && !hit)   exp_rd(ri);
            hv0 = n_hv;
            wf0 = n_wf;
            req(kind != 1, ri, kind != 0, wi, p);
            run(400, t_hv, t_wf);
            chk("rnd_hv_count", 128'(n_hv - hv0), 128'(kind != 1));
            chk("rnd_wf_count", 128'(n_wf - wf0), 128'(kind != 0));
            if (kind != 1) chk("rnd_element", 128'(h_element), 128'(elem(ri)));
            check_log("rnd");
            if (kind != 0) m_cv = 1'b0;
            if (kind != 1 && !hit) begin
                m_cv = 1'b1;
                m_ci = ri;
            end
        end
        chk("rnd_no_overrun", 128'(overrun), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
